mdu_hilo_iter: RTL and testbench

//  Iterative multiply/divide unit owning the HI/LO architectural registers for the
//  5-stage MIPS pipeline. Replaces single-cycle DIV/Hi/Lo datapath: EX issues op,

---
 rtl/mdu_hilo_iter.sv | 236 +++++++++++++++++++++++
 tb/tb_mdu_hilo_iter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo_iter.sv
// Iterative MIPS multiply/divide unit that owns HI/LO and stalls the pipeline while an op runs.
// Define MDU_MULT_EN to build the MULTU/MULT datapath; without it only DIVU/DIV are accepted.
module mdu_hilo_iter #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             flush,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             stall_req,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int N     = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = $clog2(N + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             neg_a_q, neg_a_d;
   logic             neg_b_q, neg_b_d;
   logic             dz_q, dz_d;
   logic             div_zero_q, div_zero_d;
   logic             done_q, done_d;
`ifdef MDU_MULT_EN
   logic             mul_q, mul_d;
`endif

   logic             idle;
   logic             op_ok;
   logic             accept;
   logic             rs_neg, rt_neg;
   logic [WIDTH-1:0] rs_mag, rt_mag;
   logic             neg_res;
   logic [WIDTH-1:0] q_fix, r_fix;
   logic [WIDTH-1:0] rem_s, quo_s;
   logic [WIDTH:0]   trial, diff;
`ifdef MDU_MULT_EN
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod, p_fix;
`endif

   assign idle = (state_q == S_IDLE);

`ifdef MDU_MULT_EN
   assign op_ok = 1'b1;
`else
   assign op_ok = ~op[1];
`endif

   assign accept = idle & start & op_ok & ~flush;

   assign rs_neg = op[0] & rs_val[WIDTH-1];
   assign rt_neg = op[0] & rt_val[WIDTH-1];
   assign rs_mag = rs_neg ? (~rs_val + WIDTH'(1)) : rs_val;
   assign rt_mag = rt_neg ? (~rt_val + WIDTH'(1)) : rt_val;

   // One RUN cycle: BITS_PER_CYCLE restoring-divide or shift-add steps on {rem, quo}
   always_comb begin
      rem_s = rem_q;
      quo_s = quo_q;
      trial = '0;
      diff  = '0;
`ifdef MDU_MULT_EN
      sum   = '0;
`endif
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
`ifdef MDU_MULT_EN
         if (mul_q) begin
            sum   = {1'b0, rem_s} + (quo_s[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
            rem_s = sum[WIDTH:1];
            quo_s = {sum[0], quo_s[WIDTH-1:1]};
         end else begin
`endif
            trial = {rem_s, quo_s[WIDTH-1]};
            diff  = trial - {1'b0, opb_q};
            rem_s = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
            quo_s = {quo_s[WIDTH-2:0], ~diff[WIDTH]};
`ifdef MDU_MULT_EN
         end
`endif
      end
   end

   assign neg_res = neg_a_q ^ neg_b_q;
   assign q_fix   = neg_res ? (~quo_q + WIDTH'(1)) : quo_q;
   assign r_fix   = neg_a_q ? (~rem_q + WIDTH'(1)) : rem_q;
`ifdef MDU_MULT_EN
   assign prod    = {rem_q, quo_q};
   assign p_fix   = neg_res ? (~prod + (2*WIDTH)'(1)) : prod;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      opb_d      = opb_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      neg_a_d    = neg_a_q;
      neg_b_d    = neg_b_q;
      dz_d       = dz_q;
      div_zero_d = div_zero_q;
      done_d     = 1'b0;
`ifdef MDU_MULT_EN
      mul_d      = mul_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (mthi) hi_d = wdata;
            if (mtlo) lo_d = wdata;
            if (accept) begin
               div_zero_d = 1'b0;
               neg_a_d    = rs_neg;
               neg_b_d    = rt_neg;
               cnt_d      = '0;
               rem_d      = '0;
               dz_d       = 1'b0;
               state_d    = S_RUN;
`ifdef MDU_MULT_EN
               mul_d      = op[1];
`endif
               if (op[1]) begin
                  opb_d = rs_mag;
                  quo_d = rt_mag;
               end else if (rt_val == '0) begin
                  // Divide by zero: preload the architectural result and skip RUN
                  rem_d   = rs_val;
                  quo_d   = '1;
                  dz_d    = 1'b1;
                  state_d = S_FIX;
               end else begin
                  opb_d = rt_mag;
                  quo_d = rs_mag;
               end
            end
         end
         S_RUN: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               rem_d = rem_s;
               quo_d = quo_s;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(N - 1)) state_d = S_FIX;
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            if (!flush) begin
               done_d = 1'b1;
               if (dz_q) begin
                  hi_d       = rem_q;
                  lo_d       = quo_q;
                  div_zero_d = 1'b1;
`ifdef MDU_MULT_EN
               end else if (mul_q) begin
                  hi_d = p_fix[2*WIDTH-1:WIDTH];
                  lo_d = p_fix[WIDTH-1:0];
`endif
               end else begin
                  hi_d = r_fix;
                  lo_d = q_fix;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         opb_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         neg_a_q    <= 1'b0;
         neg_b_q    <= 1'b0;
         dz_q       <= 1'b0;
         div_zero_q <= 1'b0;
         done_q     <= 1'b0;
`ifdef MDU_MULT_EN
         mul_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         opb_q      <= opb_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         neg_a_q    <= neg_a_d;
         neg_b_q    <= neg_b_d;
         dz_q       <= dz_d;
         div_zero_q <= div_zero_d;
         done_q     <= done_d;
`ifdef MDU_MULT_EN
         mul_q      <= mul_d;
`endif
      end
   end

   assign busy      = ~idle;
   assign stall_req = busy | (start & idle & op_ok);
   assign done      = done_q;
   assign div_zero  = div_zero_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

// File: tb/tb_mdu_hilo_iter.sv
// Directed bench for mdu_hilo_iter: divide results, latency, flush/reset aborts, HI/LO moves, multiply gating.
module tb_mdu_hilo_iter;
   localparam int W = 32;
   localparam logic [1:0] DIVU  = 2'b00;
   localparam logic [1:0] DIV   = 2'b01;
   localparam logic [1:0] MULTU = 2'b10;
   localparam logic [1:0] MULT  = 2'b11;

   logic         clk = 1'b0;
   logic         rst, start, flush, mthi, mtlo;
   logic [1:0]   op;
   logic [W-1:0] rs_val, rt_val, wdata;
   logic         busy, stall_req, done, div_zero;
   logic [W-1:0] hi, lo;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int t0    = 0;

   mdu_hilo_iter #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
      .flush(flush), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
      .busy(busy), .stall_req(stall_req), .done(done), .div_zero(div_zero),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents an op for one edge; returns stall_req before and busy after the start edge
   task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic stall_seen, output logic busy_seen);
      op = o; rs_val = a; rt_val = b; start = 1'b1;
      #1;
      stall_seen = stall_req;
      tick();
      start = 1'b0;
      t0 = cyc;
      busy_seen = busy;
   endtask

   // Edges counted from the start edge to the edge that raised done; -1 on timeout
   task automatic wait_done(output int lat);
      lat = -1;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (done) begin
            lat = cyc - t0;
            break;
         end
      end
   endtask

   task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
      logic s, bz;
      start_op(o, a, b, s, bz);
      wait_done(lat);
      $display("op=%0d rs=%h rt=%h -> hi=%h lo=%h div_zero=%b lat=%0d", o, a, b, hi, lo, div_zero, lat);
   endtask

   initial begin
      int   lat;
      int   ndone;
      logic s_seen, b_seen;

      rst = 1'b1; start = 1'b0; flush = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      op = DIVU; rs_val = '0; rt_val = '0; wdata = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_divz", div_zero, 0);
      check("rst_stall", stall_req, 0);

      // DIVU 100/7 with explicit stall/busy observation
      start_op(DIVU, 32'd100, 32'd7, s_seen, b_seen);
      check("divu_stall", s_seen, 1);
      check("divu_busy", b_seen, 1);
      wait_done(lat);
      $display("op=0 rs=00000064 rt=00000007 -> hi=%h lo=%h lat=%0d", hi, lo, lat);
      check("divu_lat", lat, 33);
      check("divu_lo", lo, 14);
      check("divu_hi", hi, 2);
      check("divu_busy_end", busy, 0);
      tick();
      check("divu_done_pulse", done, 0);

      run_op(DIV, 32'hFFFF_FFF9, 32'd2, lat);
      check("div_neg_lo", lo, 32'hFFFF_FFFD);
      check("div_neg_hi", hi, 32'hFFFF_FFFF);
      run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
      check("div_ovf_lo", lo, 32'h8000_0000);
      check("div_ovf_hi", hi, 0);
      run_op(DIV, 32'd7, 32'hFFFF_FFFE, lat);
      check("div_negb_lo", lo, 32'hFFFF_FFFD);
      check("div_negb_hi", hi, 1);

      run_op(DIVU, 32'd5, 32'd0, lat);
      check("dz_lat", lat, 1);
      check("dz_lo", lo, 32'hFFFF_FFFF);
      check("dz_hi", hi, 5);
      check("dz_flag", div_zero, 1);
      start_op(DIVU, 32'd100, 32'd7, s_seen, b_seen);
      check("dz_cleared", div_zero, 0);
      wait_done(lat);
      check("dz_next_lo", lo, 14);

      // mthi+mtlo together, then flush in RUN
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234_5678;
      tick();
      mthi = 1'b0; mtlo = 1'b0;
      check("mt_both_hi", hi, 32'h1234_5678);
      check("mt_both_lo", lo, 32'h1234_5678);
      start_op(DIVU, 32'd100, 32'd7, s_seen, b_seen);
      repeat (8) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_busy", busy, 0);
      check("flush_hi", hi, 32'h1234_5678);
      check("flush_lo", lo, 32'h1234_5678);
      run_op(DIVU, 32'd50, 32'd5, lat);
      check("after_flush_lat", lat, 33);
      check("after_flush_lo", lo, 10);

      // flush while in FIX (divide-by-zero path) suppresses the write
      mtlo = 1'b1; wdata = 32'hCAFE_F00D;
      tick();
      mtlo = 1'b0;
      start_op(DIVU, 32'd5, 32'd0, s_seen, b_seen);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flushfix_done", done, 0);
      check("flushfix_busy", busy, 0);
      check("flushfix_lo", lo, 32'hCAFE_F00D);
      check("flushfix_hi", hi, 0);

      // flush with start in IDLE drops the start
      flush = 1'b1;
      start_op(DIVU, 32'd100, 32'd7, s_seen, b_seen);
      flush = 1'b0;
      check("flush_start_busy", b_seen, 0);

      // start and mthi while busy are ignored
      start_op(DIVU, 32'd100, 32'd7, s_seen, b_seen);
      repeat (3) tick();
      mthi = 1'b1; wdata = 32'hA5A5_A5A5; start = 1'b1; rs_val = 32'd50; rt_val = 32'd5;
      tick();
      mthi = 1'b0; start = 1'b0;
      check("busy_mthi_hi", hi, 0);
      wait_done(lat);
      check("busy_start_lat", lat, 33);
      check("busy_start_lo", lo, 14);
      check("busy_start_hi", hi, 2);
      mthi = 1'b1;
      tick();
      mthi = 1'b0;
      check("idle_mthi_hi", hi, 32'hA5A5_A5A5);
      check("idle_mthi_lo", lo, 14);

      // same-cycle start+mthi: write now, result later
      mthi = 1'b1; wdata = 32'h5A5A_5A5A;
      start_op(DIVU, 32'd100, 32'd6, s_seen, b_seen);
      mthi = 1'b0;
      check("start_mthi_hi", hi, 32'h5A5A_5A5A);
      wait_done(lat);
      check("start_mthi_res_hi", hi, 4);
      check("start_mthi_res_lo", lo, 16);

`ifdef MDU_MULT_EN
      run_op(MULT, 32'hFFFF_FFFD, 32'd5, lat);
      check("mult_lat", lat, 33);
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFF1);
      run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
      check("multu_hi", hi, 32'hFFFF_FFFE);
      check("multu_lo", lo, 32'h0000_0001);
`else
      start_op(MULT, 32'hFFFF_FFFD, 32'd5, s_seen, b_seen);
      $display("op=3 rs=fffffffd rt=00000005 -> stall=%b busy=%b", s_seen, b_seen);
      check("nomult_stall", s_seen, 0);
      check("nomult_busy", b_seen, 0);
      ndone = 0;
      repeat (40) begin
         tick();
         if (done) ndone++;
      end
      check("nomult_done", ndone, 0);
      check("nomult_hi", hi, 4);
      check("nomult_lo", lo, 16);
`endif

      // reset mid-op
      start_op(DIVU, 32'd100, 32'd7, s_seen, b_seen);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_hi", hi, 0);
      check("midrst_lo", lo, 0);
      check("midrst_busy", busy, 0);
      ndone = 0;
      repeat (40) begin
         tick();
         if (done) ndone++;
      end
      check("midrst_done", ndone, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
